trace_collector: RTL and testbench

Parametrised multi-source trace merger that sits between the tile/NoC trace ports (`trace_signal` + trigger pairs) and `trace_buffer`. It replaces the fixed five-input `trace_handler` with an NCH-channel version. Each channel gets its own small FIFO, so bursts from several sources are absorbed instead of lost. The block arbitrates round-robin, tags every word with its source ID, applies back-pressure from the buffer, and keeps per-channel drop statistics.

---
 rtl/trace_collector.sv | 145 ++++++++++++++
 tb/tb_trace_collector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_collector.sv
// Multi-channel trace merger: per-channel FIFOs, round-robin arbitration onto a
// single {source ID, word} output register, with per-channel drop statistics.
module trace_collector #(
  parameter int Fpay       = 32,
  parameter int NCH        = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int IDw        = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int CNTw       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*Fpay-1:0] din,
  input  logic [NCH-1:0]      wr,
  input  logic [NCH-1:0]      ip_select,
  input  logic                freeze,
  input  logic                clear_stats,
  output logic [IDw+Fpay-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [NCH-1:0]      overflow,
  input  logic [IDw-1:0]      drop_sel,
  output logic [CNTw-1:0]     drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  function automatic logic [CNTw-1:0] sat_inc(input logic [CNTw-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [Fpay-1:0]     mem [NCH][FIFO_DEPTH];
  logic [PW-1:0]       wptr [NCH];
  logic [PW-1:0]       rptr [NCH];
  logic [PW:0]         occ [NCH];
  logic [CNTw-1:0]     drop [NCH];
  logic [NCH-1:0]      cap, push, pop, req;

  logic [IDw-1:0]      rr_p0;
  logic                vld_p1;
  logic [IDw+Fpay-1:0] data_p1;

  logic                load, gnt;
  logic [NCH-1:0]      rot;
  logic [IDw:0]        off, sum_raw, sum;
  logic [IDw-1:0]      gnt_id, nxt_rr;
  logic [Fpay-1:0]     head;

  // Capture qualification; fullness is the occupancy at the start of the cycle
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cap[i]  = wr[i] & ip_select[i] & ~freeze;
      push[i] = cap[i] & (occ[i] != (PW+1)'(FIFO_DEPTH));
      req[i]  = (occ[i] != '0);
    end
  end

  // Round-robin: rotate requests so the search starts at rr_p0, take the lowest set bit
  always_comb begin
    load    = ~vld_p1 | dout_ready;
    gnt     = load & (|req);
    rot     = NCH'({req, req} >> rr_p0);
    off     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDw+1)'(i);
    end
    sum_raw = {1'b0, rr_p0} + off;
    sum     = (sum_raw >= (IDw+1)'(NCH)) ? sum_raw - (IDw+1)'(NCH) : sum_raw;
    gnt_id  = sum[IDw-1:0];
    nxt_rr  = (gnt_id == IDw'(NCH - 1)) ? '0 : gnt_id + 1'b1;
    pop     = '0;
    head    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt && gnt_id == IDw'(i)) begin
        pop[i] = 1'b1;
        head   = mem[i][rptr[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem[i][wptr[i]] <= din[i*Fpay +: Fpay];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        occ[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        occ[i] <= occ[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      end
    end
  end

  // Drop statistics; clear takes priority over a same-cycle drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) drop[i] <= '0;
      overflow <= '0;
    end else if (clear_stats) begin
      for (int i = 0; i < NCH; i++) drop[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cap[i] && !push[i]) begin
          drop[i]     <= sat_inc(drop[i]);
          overflow[i] <= 1'b1;
        end
      end
    end
  end

  // Output stage: single register, loaded on grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_p0   <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (gnt) begin
      rr_p0   <= nxt_rr;
      vld_p1  <= 1'b1;
      data_p1 <= {gnt_id, head};
    end else if (dout_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign dout       = data_p1;
  assign dout_valid = vld_p1;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (drop_sel == IDw'(i)) drop_cnt = drop[i];
    end
  end

endmodule

// File: tb/tb_trace_collector.sv
// Bench for trace_collector: constant vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_trace_collector;
  localparam int NCH = 5, FP = 32, DEPTH = 4, IDW = 3, CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*FP-1:0] din;
  logic [NCH-1:0]    wr, ip_select, overflow;
  logic              freeze, clear_stats, dout_valid, dout_ready;
  logic [IDW+FP-1:0] dout;
  logic [IDW-1:0]    drop_sel;
  logic [CW-1:0]     drop_cnt;

  always #5 clk = ~clk;

  trace_collector #(.Fpay(FP), .NCH(NCH), .FIFO_DEPTH(DEPTH), .IDw(IDW), .CNTw(CW)) dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .ip_select(ip_select),
    .freeze(freeze), .clear_stats(clear_stats), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overflow(overflow), .drop_sel(drop_sel), .drop_cnt(drop_cnt)
  );

  int n_checks = 0, n_errors = 0;

  logic [FP-1:0]     mq [NCH][$];
  int                m_drop [NCH];
  logic [NCH-1:0]    m_ovf;
  logic              m_vld;
  logic [IDW+FP-1:0] m_dout;
  int                m_ptr;

  typedef struct {
    logic [NCH-1:0] wr;
    logic [31:0]    base;
    logic           ready;
    logic           ev;
    logic [2:0]     eid;
    logic [31:0]    ed;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      m_drop[i] = 0;
    end
    m_ovf = '0; m_vld = 1'b0; m_dout = '0; m_ptr = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_edge();
    int sz [NCH];
    int gid, c;
    bit g;
    logic [FP-1:0] w;
    g = 0; gid = 0;
    for (int i = 0; i < NCH; i++) sz[i] = mq[i].size();
    if (!m_vld || dout_ready) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (!g && sz[c] > 0) begin g = 1; gid = c; end
      end
    end
    if (g) begin
      w = mq[gid].pop_front();
      m_dout = {IDW'(gid), w};
      m_vld = 1'b1;
      m_ptr = (gid + 1) % NCH;
    end else if (dout_ready) begin
      m_vld = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (wr[i] && ip_select[i] && !freeze) begin
        if (sz[i] < DEPTH) mq[i].push_back(din[i*FP +: FP]);
        else begin
          m_drop[i] = (m_drop[i] < SAT) ? m_drop[i] + 1 : SAT;
          m_ovf[i] = 1'b1;
        end
      end
    end
    if (clear_stats) begin
      for (int i = 0; i < NCH; i++) m_drop[i] = 0;
      m_ovf = '0;
    end
  endtask

  task automatic model_check();
    logic [63:0] e;
    chk("dout_valid", 64'(dout_valid), 64'(m_vld));
    if (m_vld) chk("dout", 64'(dout), 64'(m_dout));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    e = (int'(drop_sel) < NCH) ? 64'(m_drop[int'(drop_sel)]) : 64'd0;
    chk("drop_cnt", 64'(drop_cnt), e);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle();
    wr = '0; din = '0; ip_select = '1; freeze = 1'b0; clear_stats = 1'b0;
    dout_ready = 1'b1; drop_sel = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] got [$];
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(dout_valid), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single word on channel 2 straight after reset
    wr = 5'b00100; din[2*FP +: FP] = 32'hDEADBEEF;
    step();
    chk("single_lat0", 64'(dout_valid), 64'd0);
    wr = '0;
    step();
    chk("single_valid", 64'(dout_valid), 64'd1);
    chk("single_dout", 64'(dout), {29'd0, 3'd2, 32'hDEADBEEF});
    chk("single_ovf", 64'(overflow), 64'd0);
    step();
    chk("single_once", 64'(dout_valid), 64'd0);

    // Simultaneous writes, second round while the pointer sits at channel 4
    do_reset();
    tbl[0]  = '{5'h1F, 32'h100, 1'b1, 1'b0, 3'd0, 32'h0};
    tbl[1]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd0, 32'h100};
    tbl[2]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd1, 32'h101};
    tbl[3]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd2, 32'h102};
    tbl[4]  = '{5'h1F, 32'h200, 1'b1, 1'b1, 3'd3, 32'h103};
    tbl[5]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd4, 32'h104};
    tbl[6]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd0, 32'h200};
    tbl[7]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd1, 32'h201};
    tbl[8]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd2, 32'h202};
    tbl[9]  = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd3, 32'h203};
    tbl[10] = '{5'h00, 32'h0,   1'b1, 1'b1, 3'd4, 32'h204};
    tbl[11] = '{5'h00, 32'h0,   1'b1, 1'b0, 3'd0, 32'h0};
    for (int r = 0; r < 12; r++) begin
      wr = tbl[r].wr;
      for (int i = 0; i < NCH; i++) din[i*FP +: FP] = tbl[r].base + 32'(i);
      dout_ready = tbl[r].ready;
      step();
      chk("tbl_valid", 64'(dout_valid), 64'(tbl[r].ev));
      if (tbl[r].ev) chk("tbl_dout", 64'(dout), 64'({tbl[r].eid, tbl[r].ed}));
    end

    // Overflow on channel 1 with the consumer stalled
    wr = '0; dout_ready = 1'b0; drop_sel = 3'd1;
    for (int k = 0; k < 6; k++) begin
      wr = 5'b00010; din[FP +: FP] = 32'(k);
      step();
    end
    wr = '0;
    step();
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'h2);
    dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("ovf_order_valid", 64'(dout_valid), 64'd1);
      chk("ovf_order", 64'(dout), {29'd0, 3'd1, 32'(k)});
      step();
    end
    chk("ovf_drained", 64'(dout_valid), 64'd0);

    // Disabled channel, then freeze with a non-empty FIFO
    ip_select = 5'b10111; drop_sel = 3'd3;
    for (int k = 0; k < 3; k++) begin
      wr = 5'b01000; din[3*FP +: FP] = $urandom;
      step();
      chk("disabled_out", 64'(dout_valid), 64'd0);
    end
    wr = '0;
    step();
    chk("disabled_drop", 64'(drop_cnt), 64'd0);
    ip_select = '1; dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr = 5'b00100; din[2*FP +: FP] = 32'h300 + 32'(k);
      step();
    end
    freeze = 1'b1; dout_ready = 1'b1; din[2*FP +: FP] = 32'h3FF;
    for (int c = 0; c < 6; c++) begin
      if (dout_valid && dout_ready) got.push_back(dout[31:0]);
      step();
    end
    chk("freeze_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk("freeze_data", 64'(got[k]), 64'h300 + 64'(k));
    freeze = 1'b0; wr = '0;

    // Saturate drop[0] then clear it on a cycle that also drops
    dout_ready = 1'b0; drop_sel = 3'd0;
    for (int k = 0; k < 25; k++) begin
      wr = 5'b00001; din[FP-1:0] = 32'h500 + 32'(k);
      step();
    end
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd15);
    chk("sat_ovf0", 64'(overflow[0]), 64'd1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0; wr = '0;
    step();
    chk("clear_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("clear_ovf", 64'(overflow), 64'd0);

    // Reset while a word is held on the output and the FIFO is non-empty
    chk("pre_reset_valid", 64'(dout_valid), 64'd1);
    do_reset();
    dout_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("post_reset_quiet", 64'(dout_valid), 64'd0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      wr          = NCH'($urandom);
      ip_select   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      freeze      = ($urandom_range(0, 15) == 0);
      clear_stats = ($urandom_range(0, 63) == 0);
      dout_ready  = ($urandom_range(0, 3) != 0);
      drop_sel    = IDW'($urandom_range(0, 7));
      for (int i = 0; i < NCH; i++) din[i*FP +: FP] = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
